// File: rtl/adc_serial_pkg.sv
// Shared constants and state encoding for the serial ADC link (transmitter and reader).
// Frame = ADC_LEAD_ZEROS zero samples followed by ADC_DATA_W data bits, MSB first.
package adc_serial_pkg;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_LEAD_ZEROS = 3;
    localparam int ADC_FRAME_LEN  = ADC_LEAD_ZEROS + ADC_DATA_W;
    localparam int ADC_CNT_W      = $clog2(ADC_FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_QUIET,
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT
    } adc_state_e;

endpackage

// File: rtl/adc_serial_tx_piso.sv
// Parallel-load MSB-first shift register; load wins over shift, msb_o is the current head bit.
// One-cycle update latency, no backpressure (enables are driven by the owning controller).
module adc_piso #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] par_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = par_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/adc_serial_tx.sv
// Serial ADC responder: one registered frame (lead zeros + sample MSB-first) per cs assertion; 1-deep
// valid/ready holding register, ready = hold empty. Optional lead-bit fault injection under FAULT_INJECT_EN.
module adc_serial_tx
    import adc_serial_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int LEAD_ZEROS = ADC_LEAD_ZEROS,
    parameter int QUIET_MIN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_cs_in,
    output logic              data_out,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid_in,
    output logic              sample_ready_out,
`ifdef FAULT_INJECT_EN
    input  logic              fault_lead_in,
`endif
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              underrun_out,
    output logic              abort_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int QW    = (QUIET_MIN > 0) ? $clog2(QUIET_MIN + 1) : 1;

    adc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [DATA_W-1:0] hold_q, hold_d, last_q, last_d;
    logic              hold_full_q, hold_full_d;
    logic              data_q, data_d;
    logic              done_q, done_d, under_q, under_d, abort_q, abort_d;
    logic              sr_load, sr_shift, sr_msb, consume, accept;
    logic              fault_lead;

`ifdef FAULT_INJECT_EN
    assign fault_lead = fault_lead_in;
`else
    assign fault_lead = 1'b0;
`endif

    adc_piso #(.W(DATA_W)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .par_i   (hold_full_q ? hold_q : last_q),
        .msb_o   (sr_msb)
    );

    assign accept = sample_valid_in && !hold_full_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quiet_d  = quiet_q;
        last_d   = last_q;
        data_d   = 1'b0;
        done_d   = 1'b0;
        under_d  = 1'b0;
        abort_d  = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        consume  = 1'b0;
        case (state_q)
            ST_QUIET: begin
                if (!adc_cs_in) begin
                    quiet_d = '0;
                end else if ((int'(quiet_q) + 1) >= QUIET_MIN) begin
                    quiet_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    quiet_d = quiet_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!adc_cs_in) begin
                    state_d = ST_LEAD;
                    sr_load = 1'b1;
                    cnt_d   = '0;
                    data_d  = fault_lead;
                    if (hold_full_q) begin
                        consume = 1'b1;
                        last_d  = hold_q;
                    end else begin
                        under_d = 1'b1;
                    end
                end
            end
            ST_LEAD: begin
                if (adc_cs_in) begin
                    abort_d = 1'b1;
                    state_d = ST_QUIET;
                    quiet_d = '0;
                end else if (cnt_q == CNT_W'(LEAD_ZEROS - 2)) begin
                    data_d   = sr_msb;
                    sr_shift = 1'b1;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                // cnt_q counts data bits already driven; the edge after the last bit closes the frame
                if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d = ST_QUIET;
                    quiet_d = '0;
                end else if (adc_cs_in) begin
                    abort_d = 1'b1;
                    state_d = ST_QUIET;
                    quiet_d = '0;
                end else begin
                    data_d   = sr_msb;
                    sr_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    done_d   = (cnt_q == CNT_W'(DATA_W - 1));
                end
            end
            default: state_d = ST_QUIET;
        endcase

        hold_full_d = hold_full_q && !consume;
        hold_d      = hold_q;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_QUIET;
            cnt_q       <= '0;
            quiet_q     <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            hold_full_q <= 1'b0;
            data_q      <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quiet_q     <= quiet_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            done_q      <= done_d;
            under_q     <= under_d;
            abort_q     <= abort_d;
        end
    end

    assign data_out         = data_q;
    assign sample_ready_out = !hold_full_q;
    assign busy_out         = (state_q == ST_LEAD) || (state_q == ST_SHIFT);
    assign frame_done_out   = done_q;
    assign underrun_out     = under_q;
    assign abort_out        = abort_q;

endmodule
